// File: rtl/regfile_wb_queue_if.sv
// Writeback request, register-file write port and read-correction bundle
// for regfile_wb_queue.
interface regfile_wb_queue_if #(
  parameter int REG_AW = 5,
  parameter int DW     = 32
);
  logic              alu_valid;
  logic              alu_ready;
  logic [REG_AW-1:0] alu_reg;
  logic [DW-1:0]     alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [REG_AW-1:0] mem_reg;
  logic [DW-1:0]     mem_data;
  logic              RegWrite;
  logic [REG_AW-1:0] WriteReg;
  logic [DW-1:0]     WriteData;
  logic [REG_AW-1:0] ReadReg1;
  logic [REG_AW-1:0] ReadReg2;
  logic [DW-1:0]     RegData1;
  logic [DW-1:0]     RegData2;
  logic [DW-1:0]     ReadData1;
  logic [DW-1:0]     ReadData2;
  logic              hazard1;
  logic              hazard2;

  modport master (
    output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
    output ReadReg1, ReadReg2, RegData1, RegData2,
    input  alu_ready, mem_ready, RegWrite, WriteReg, WriteData,
    input  ReadData1, ReadData2, hazard1, hazard2
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
    input  ReadReg1, ReadReg2, RegData1, RegData2,
    output alu_ready, mem_ready, RegWrite, WriteReg, WriteData,
    output ReadData1, ReadData2, hazard1, hazard2
  );
endinterface

// File: rtl/regfile_wb_queue.sv
// In-order writeback queue in front of the 32x32 register file with read-port
// correction. Define WBQ_FWD_EN to forward queued data; otherwise hazards are flagged.
module regfile_wb_queue #(
  parameter int DEPTH  = 4,
  parameter int REG_AW = 5,
  parameter int DW     = 32,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clock,
  input  logic          reset,
  regfile_wb_queue_if.slave bus,
  output logic [CW-1:0] count
);

  logic [REG_AW-1:0] reg_q_r  [DEPTH];
  logic [DW-1:0]     data_q_r [DEPTH];
  logic [PW-1:0]     rd_ptr_r;
  logic [PW-1:0]     wr_ptr_r;
  logic [CW-1:0]     count_r;

  logic              pop_s;
  logic [CW-1:0]     free_s;
  logic              mem_ready_s;
  logic              alu_ready_s;
  logic              mem_push_s;
  logic              alu_push_s;
  logic [PW-1:0]     alu_slot_s;
  logic              reg_write_s;
  logic [REG_AW-1:0] write_reg_s;
  logic [DW-1:0]     write_data_s;
  logic              match1_s;
  logic              match2_s;
  logic [DW-1:0]     fwd1_s;
  logic [DW-1:0]     fwd2_s;

  assign pop_s = (count_r != {CW{1'b0}});

  // Acceptance: a draining head frees its slot this edge; mem claims first
  always_comb begin
    free_s      = CW'(DEPTH) - count_r + CW'(pop_s);
    mem_ready_s = (free_s >= CW'(1));
    alu_ready_s = (free_s >= CW'(2)) | ((free_s >= CW'(1)) & ~bus.mem_valid);
    mem_push_s  = bus.mem_valid & mem_ready_s & (bus.mem_reg != {REG_AW{1'b0}});
    alu_push_s  = bus.alu_valid & alu_ready_s & (bus.alu_reg != {REG_AW{1'b0}});
    alu_slot_s  = wr_ptr_r + PW'(mem_push_s);
  end

  // Queue storage, pointers and occupancy
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        reg_q_r[i]  <= {REG_AW{1'b0}};
        data_q_r[i] <= {DW{1'b0}};
      end
    end else begin
      if (mem_push_s) begin
        reg_q_r[wr_ptr_r]  <= bus.mem_reg;
        data_q_r[wr_ptr_r] <= bus.mem_data;
      end
      if (alu_push_s) begin
        reg_q_r[alu_slot_s]  <= bus.alu_reg;
        data_q_r[alu_slot_s] <= bus.alu_data;
      end
      rd_ptr_r <= rd_ptr_r + PW'(pop_s);
      wr_ptr_r <= wr_ptr_r + PW'(mem_push_s) + PW'(alu_push_s);
      count_r  <= count_r - CW'(pop_s) + CW'(mem_push_s) + CW'(alu_push_s);
    end
  end

  // Head entry drives the register-file write port
  always_comb begin
    if (pop_s) begin
      reg_write_s  = 1'b1;
      write_reg_s  = reg_q_r[rd_ptr_r];
      write_data_s = data_q_r[rd_ptr_r];
    end else begin
      reg_write_s  = 1'b0;
      write_reg_s  = {REG_AW{1'b0}};
      write_data_s = {DW{1'b0}};
    end
  end

  // Scan oldest to youngest so the youngest matching entry is the one kept
  always_comb begin
    match1_s = 1'b0;
    match2_s = 1'b0;
    fwd1_s   = {DW{1'b0}};
    fwd2_s   = {DW{1'b0}};
    for (int age = 0; age < DEPTH; age++) begin
      if (CW'(age) < count_r) begin
        if ((bus.ReadReg1 != {REG_AW{1'b0}}) &&
            (reg_q_r[rd_ptr_r + PW'(age)] == bus.ReadReg1)) begin
          match1_s = 1'b1;
`ifdef WBQ_FWD_EN
          fwd1_s   = data_q_r[rd_ptr_r + PW'(age)];
`endif
        end else begin
          match1_s = match1_s;
        end
        if ((bus.ReadReg2 != {REG_AW{1'b0}}) &&
            (reg_q_r[rd_ptr_r + PW'(age)] == bus.ReadReg2)) begin
          match2_s = 1'b1;
`ifdef WBQ_FWD_EN
          fwd2_s   = data_q_r[rd_ptr_r + PW'(age)];
`endif
        end else begin
          match2_s = match2_s;
        end
      end else begin
        match1_s = match1_s;
        match2_s = match2_s;
      end
    end
  end

  assign bus.alu_ready = alu_ready_s;
  assign bus.mem_ready = mem_ready_s;
  assign bus.RegWrite  = reg_write_s;
  assign bus.WriteReg  = write_reg_s;
  assign bus.WriteData = write_data_s;
  assign count         = count_r;

`ifdef WBQ_FWD_EN
  assign bus.ReadData1 = match1_s ? fwd1_s : bus.RegData1;
  assign bus.ReadData2 = match2_s ? fwd2_s : bus.RegData2;
  assign bus.hazard1   = 1'b0;
  assign bus.hazard2   = 1'b0;
`else
  // Without forwarding the raw read passes through and the consumer must stall
  assign bus.ReadData1 = bus.RegData1 | (fwd1_s & {DW{1'b0}});
  assign bus.ReadData2 = bus.RegData2 | (fwd2_s & {DW{1'b0}});
  assign bus.hazard1   = match1_s;
  assign bus.hazard2   = match2_s;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench for regfile_wb_queue: scoreboard of accepted writes,
// a table of fill/drain vectors and hand-written corner sequences.
module tb_regfile_wb_queue;
  localparam int DEPTH  = 4;
  localparam int REG_AW = 5;
  localparam int DW     = 32;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset;
  logic [CW-1:0] count;

  regfile_wb_queue_if #(.REG_AW(REG_AW), .DW(DW)) bus ();

  regfile_wb_queue #(.DEPTH(DEPTH), .REG_AW(REG_AW), .DW(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .count (count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [REG_AW-1:0] r;
    logic [DW-1:0]     d;
  } wr_t;

  typedef struct {
    logic              mv;
    logic [REG_AW-1:0] mr;
    logic [DW-1:0]     md;
    logic              av;
    logic [REG_AW-1:0] ar;
    logic [DW-1:0]     ad;
    int                exp_cnt;
    logic              exp_ar;
  } vec_t;

  wr_t  sb_q[$];
  vec_t vecs[10];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic pend_mem, pend_alu;
  wr_t  pend_mem_e, pend_alu_e;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(input logic mv, input logic [REG_AW-1:0] mr, input logic [DW-1:0] md,
                               input logic av, input logic [REG_AW-1:0] ar, input logic [DW-1:0] ad,
                               input int exp_cnt, input logic exp_ar);
    vec_t v;
    v.mv = mv; v.mr = mr; v.md = md; v.av = av; v.ar = ar; v.ad = ad;
    v.exp_cnt = exp_cnt; v.exp_ar = exp_ar;
    return v;
  endfunction

  // Youngest queued write to rr (never register 0)
  function automatic logic model_hit(input logic [REG_AW-1:0] rr, output logic [DW-1:0] d);
    d = '0;
    if (rr == '0) return 1'b0;
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].r == rr) begin
        d = sb_q[i].d;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic set_idle();
    bus.mem_valid = 1'b0; bus.mem_reg = '0; bus.mem_data = '0;
    bus.alu_valid = 1'b0; bus.alu_reg = '0; bus.alu_data = '0;
  endtask

  // Drive one cycle's requests (called just after a falling edge) and check outputs
  task automatic apply(input logic mv, input logic [REG_AW-1:0] mr, input logic [DW-1:0] md,
                       input logic av, input logic [REG_AW-1:0] ar, input logic [DW-1:0] ad);
    int cnt, free;
    logic exp_mr, exp_ar, h1, h2;
    logic [DW-1:0] d1, d2;
    bus.mem_valid = mv; bus.mem_reg = mr; bus.mem_data = md;
    bus.alu_valid = av; bus.alu_reg = ar; bus.alu_data = ad;
    #1;
    cnt    = sb_q.size();
    free   = DEPTH - cnt + ((cnt != 0) ? 1 : 0);
    exp_mr = (free >= 1);
    exp_ar = (free >= 2) || ((free >= 1) && !mv);
    check("count", 32'(count), 32'(cnt));
    check("RegWrite", 32'(bus.RegWrite), 32'(cnt != 0));
    check("WriteReg", 32'(bus.WriteReg), (cnt != 0) ? 32'(sb_q[0].r) : 32'd0);
    check("WriteData", bus.WriteData, (cnt != 0) ? sb_q[0].d : 32'd0);
    check("mem_ready", 32'(bus.mem_ready), 32'(exp_mr));
    check("alu_ready", 32'(bus.alu_ready), 32'(exp_ar));
    h1 = model_hit(bus.ReadReg1, d1);
    h2 = model_hit(bus.ReadReg2, d2);
`ifdef WBQ_FWD_EN
    check("ReadData1", bus.ReadData1, h1 ? d1 : bus.RegData1);
    check("ReadData2", bus.ReadData2, h2 ? d2 : bus.RegData2);
    check("hazard1", 32'(bus.hazard1), 32'd0);
    check("hazard2", 32'(bus.hazard2), 32'd0);
`else
    check("ReadData1", bus.ReadData1, bus.RegData1);
    check("ReadData2", bus.ReadData2, bus.RegData2);
    check("hazard1", 32'(bus.hazard1), 32'(h1));
    check("hazard2", 32'(bus.hazard2), 32'(h2));
`endif
    pend_mem   = mv && exp_mr && (mr != '0);
    pend_alu   = av && exp_ar && (ar != '0);
    pend_mem_e = '{r: mr, d: md};
    pend_alu_e = '{r: ar, d: ad};
  endtask

  // Rising edge: the head drains, accepted requests enter mem first then alu
  task automatic advance();
    @(posedge clock);
    if (sb_q.size() != 0) void'(sb_q.pop_front());
    if (pend_mem) sb_q.push_back(pend_mem_e);
    if (pend_alu) sb_q.push_back(pend_alu_e);
    pend_mem = 1'b0;
    pend_alu = 1'b0;
    @(negedge clock);
  endtask

  task automatic idle_cycle();
    apply(1'b0, '0, '0, 1'b0, '0, '0);
    advance();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    pend_mem = 1'b0; pend_alu = 1'b0;
    reset = 1'b0;
    set_idle();
    bus.ReadReg1 = '0; bus.ReadReg2 = '0;
    bus.RegData1 = 32'h1111_1111; bus.RegData2 = 32'h2222_2222;

    vecs[0] = mkv(1'b1, 5'd8,  32'hA000_0008, 1'b1, 5'd9,  32'hB000_0009, 0, 1'b1);
    vecs[1] = mkv(1'b1, 5'd10, 32'hA000_000A, 1'b1, 5'd11, 32'hB000_000B, 2, 1'b1);
    vecs[2] = mkv(1'b1, 5'd12, 32'hA000_000C, 1'b1, 5'd13, 32'hB000_000D, 3, 1'b1);
    vecs[3] = mkv(1'b1, 5'd14, 32'hA000_000E, 1'b1, 5'd15, 32'hB000_000F, 4, 1'b0);
    vecs[4] = mkv(1'b1, 5'd16, 32'hA000_0010, 1'b1, 5'd17, 32'hB000_0011, 4, 1'b0);
    vecs[5] = mkv(1'b1, 5'd18, 32'hA000_0012, 1'b1, 5'd19, 32'hB000_0013, 4, 1'b0);
    vecs[6] = mkv(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         4, 1'b1);
    vecs[7] = mkv(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         3, 1'b1);
    vecs[8] = mkv(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         2, 1'b1);
    vecs[9] = mkv(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1, 1'b1);

    // Reset state
    repeat (2) @(negedge clock);
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_RegWrite", 32'(bus.RegWrite), 32'd0);
    check("rst_WriteReg", 32'(bus.WriteReg), 32'd0);
    check("rst_WriteData", bus.WriteData, 32'd0);
    check("rst_hazard1", 32'(bus.hazard1), 32'd0);
    check("rst_hazard2", 32'(bus.hazard2), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Single ALU write: one-cycle latency, then idle
    apply(1'b0, '0, '0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    advance();
    apply(1'b0, '0, '0, 1'b0, '0, '0);
    check("t2_RegWrite", 32'(bus.RegWrite), 32'd1);
    check("t2_WriteReg", 32'(bus.WriteReg), 32'd5);
    check("t2_WriteData", bus.WriteData, 32'hDEAD_BEEF);
    advance();
    apply(1'b0, '0, '0, 1'b0, '0, '0);
    check("t2_RegWrite_off", 32'(bus.RegWrite), 32'd0);
    advance();

    // Simultaneous mem and alu: mem is written first
    apply(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    advance();
    apply(1'b0, '0, '0, 1'b0, '0, '0);
    check("t3_first_reg", 32'(bus.WriteReg), 32'd3);
    check("t3_first_data", bus.WriteData, 32'h11);
    advance();
    apply(1'b0, '0, '0, 1'b0, '0, '0);
    check("t3_second_reg", 32'(bus.WriteReg), 32'd4);
    check("t3_second_data", bus.WriteData, 32'h22);
    advance();
    idle_cycle();

    // Register 0 is accepted but never written
    apply(1'b0, '0, '0, 1'b1, 5'd0, 32'h55);
    check("t6_alu_ready", 32'(bus.alu_ready), 32'd1);
    advance();
    apply(1'b0, '0, '0, 1'b0, '0, '0);
    check("t6_count", 32'(count), 32'd0);
    check("t6_RegWrite", 32'(bus.RegWrite), 32'd0);
    advance();

    // Fill to full with both requesters valid, then drain across the wrap
    for (int i = 0; i < 10; i++) begin
      apply(vecs[i].mv, vecs[i].mr, vecs[i].md, vecs[i].av, vecs[i].ar, vecs[i].ad);
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_cnt));
      check($sformatf("vec%0d_alu_ready", i), 32'(bus.alu_ready), 32'(vecs[i].exp_ar));
      advance();
    end
    idle_cycle();

    // Two pending writes to r7: the younger one is the bypass source
    bus.ReadReg1 = 5'd7; bus.RegData1 = 32'h1234_5678;
    bus.ReadReg2 = 5'd0; bus.RegData2 = 32'hCAFE_F00D;
    apply(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB);
    advance();
    apply(1'b0, '0, '0, 1'b0, '0, '0);
`ifdef WBQ_FWD_EN
    check("t5_ReadData1", bus.ReadData1, 32'hB);
    check("t5_hazard1", 32'(bus.hazard1), 32'd0);
`else
    check("t5_ReadData1", bus.ReadData1, 32'h1234_5678);
    check("t5_hazard1", 32'(bus.hazard1), 32'd1);
`endif
    check("t5_ReadData2_r0", bus.ReadData2, 32'hCAFE_F00D);
    check("t5_hazard2_r0", 32'(bus.hazard2), 32'd0);
    advance();
    idle_cycle();
    apply(1'b0, '0, '0, 1'b0, '0, '0);
    check("t5_empty_ReadData1", bus.ReadData1, 32'h1234_5678);
    check("t5_empty_hazard1", 32'(bus.hazard1), 32'd0);
    advance();
    bus.ReadReg1 = '0;

    // Reset asserted with three writes queued: all are discarded
    apply(1'b1, 5'd1, 32'h101, 1'b1, 5'd2, 32'h102);
    advance();
    apply(1'b1, 5'd20, 32'h103, 1'b1, 5'd21, 32'h104);
    advance();
    set_idle();
    #1;
    check("t1_pre_count", 32'(count), 32'd3);
    reset = 1'b0;
    #1;
    check("t1_count", 32'(count), 32'd0);
    check("t1_RegWrite", 32'(bus.RegWrite), 32'd0);
    sb_q.delete();
    @(posedge clock);
    #1;
    check("t1_hold_RegWrite", 32'(bus.RegWrite), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
